// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, opcode/funct
// values, ALU operation codes and PC source selects.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_EXEC_R   = 4'd3,
        ST_EXEC_I   = 4'd4,
        ST_MEM_ADDR = 4'd5,
        ST_MEM_RD   = 4'd6,
        ST_MEM_WR   = 4'd7,
        ST_WB_R     = 4'd8,
        ST_WB_I     = 4'd9,
        ST_WB_MEM   = 4'd10,
        ST_BRANCH   = 4'd11,
        ST_JUMP     = 4'd12,
        ST_ILLEGAL  = 4'd13
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_alu_decode.sv
// R-type funct decoder: maps funct to an ALU operation and flags unsupported codes.
module mips_alu_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic       legal
);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        alu_op = ALU_ADD;
        legal  = 1'b1;
        case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_SLT:  alu_op = ALU_SLT;
            default: legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM with a mem_req/mem_ready handshake.
// Optional MIPS_CTRL_PERF_EN adds retired-instruction and stall-cycle counters.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_read,
    output logic        mem_write,
    output logic        iord,
    output logic        ir_write,
    output logic        reg_dst,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        alu_src,
    output logic [2:0]  alu_op,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        instr_done,
    output logic        illegal,
    output logic [3:0]  state
`ifdef MIPS_CTRL_PERF_EN
    ,
    output logic [31:0] retired_cnt,
    output logic [31:0] stall_cnt
`endif
);

    state_e     state_q, state_d;
    logic [2:0] r_alu_op;
    logic       funct_legal;

    mips_alu_decode u_alu_decode (
        .funct  (funct),
        .alu_op (r_alu_op),
        .legal  (funct_legal)
    );

    // NOTE: state flops use non-blocking assignments; the combinational block below uses blocking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    assign state = state_q;

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        alu_op     = ALU_ADD;
        pc_write   = 1'b0;
        pc_src     = PC_SEQ;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                mem_req  = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = funct_legal ? ST_EXEC_R : ST_ILLEGAL;
                    OP_ADDI:      state_d = ST_EXEC_I;
                    OP_LW, OP_SW: state_d = ST_MEM_ADDR;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_J:         state_d = ST_JUMP;
                    default:      state_d = ST_ILLEGAL;
                endcase
            end
            ST_EXEC_R: begin
                alu_op  = r_alu_op;
                state_d = ST_WB_R;
            end
            ST_EXEC_I: begin
                alu_src = 1'b1;
                state_d = ST_WB_I;
            end
            ST_MEM_ADDR: begin
                alu_src = 1'b1;
                state_d = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            end
            ST_MEM_RD: begin
                mem_req  = 1'b1;
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) state_d = ST_WB_MEM;
            end
            ST_MEM_WR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = ST_FETCH;
                end
            end
            ST_WB_R, ST_WB_I, ST_WB_MEM: begin
                reg_dst    = (state_q == ST_WB_R);
                mem_to_reg = (state_q == ST_WB_MEM);
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_op     = ALU_SUB;
                pc_src     = PC_BRANCH;
                pc_write   = zero;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_JUMP: begin
                pc_src     = PC_JUMP;
                pc_write   = 1'b1;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_ILLEGAL: begin
                illegal    = 1'b1;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef MIPS_CTRL_PERF_EN
    logic [31:0] retired_cnt_q, retired_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        mem_wait;

    // A stall is any memory-phase cycle in which the access has not completed.
    assign mem_wait = (state_q == ST_FETCH || state_q == ST_MEM_RD || state_q == ST_MEM_WR)
                      && !mem_ready;

    always_comb begin
        retired_cnt_d = retired_cnt_q + ((instr_done && !illegal) ? 32'd1 : 32'd0);
        stall_cnt_d   = stall_cnt_q + (mem_wait ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt_q <= 32'd0;
            stall_cnt_q   <= 32'd0;
        end else begin
            retired_cnt_q <= retired_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign retired_cnt = retired_cnt_q;
    assign stall_cnt   = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench: each instruction is expanded into an expected per-cycle
// trace of control outputs and replayed against the controller.
module tb_mips_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  opcode = '0;
    logic [5:0]  funct = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_read, mem_write, iord, ir_write, reg_dst, reg_write;
    logic        mem_to_reg, alu_src, pc_write, instr_done, illegal;
    logic [2:0]  alu_op;
    logic [1:0]  pc_src;
    logic [3:0]  state;
`ifdef MIPS_CTRL_PERF_EN
    logic [31:0] retired_cnt, stall_cnt;
`endif

    always #5 clk = ~clk;

    mips_multicycle_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .iord       (iord),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .instr_done (instr_done),
        .illegal    (illegal),
        .state      (state)
`ifdef MIPS_CTRL_PERF_EN
        ,
        .retired_cnt(retired_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    typedef struct packed {
        logic       mem_req, mem_read, mem_write, iord, ir_write;
        logic       reg_dst, reg_write, mem_to_reg, alu_src;
        logic [2:0] alu_op;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       instr_done, illegal;
        logic [3:0] state;
    } outs_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       rdy;
        logic       z;
        outs_t      exp;
    } cyc_t;

    outs_t      act;
    cyc_t       trace[$];
    int         passed = 0;
    int         total = 0;
    int         cyc_no = 0;
    int         exp_retired = 0;
    int         exp_stall = 0;
    logic [5:0] m_op, m_fn;
    logic [5:0] legal_fns[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    assign act = {mem_req, mem_read, mem_write, iord, ir_write, reg_dst, reg_write,
                  mem_to_reg, alu_src, alu_op, pc_write, pc_src, instr_done, illegal, state};

    function automatic outs_t st(input int s);
        outs_t o = '0;
        o.state = 4'(s);
        return o;
    endfunction

    task automatic push(input logic rdy, input logic z, input outs_t o);
        cyc_t c;
        c.op = m_op; c.fn = m_fn; c.rdy = rdy; c.z = z; c.exp = o;
        trace.push_back(c);
    endtask

    // Reference model: expected outputs of every cycle of one instruction.
    task automatic model_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                               input int wf, input int wm);
        outs_t o;
        logic [2:0] aop;
        bit fn_ok, bad;
        m_op = op; m_fn = fn;
        fn_ok = 1'b1; aop = 3'd0; bad = 1'b0;
        case (fn)
            6'h20: aop = 3'd0;
            6'h22: aop = 3'd1;
            6'h24: aop = 3'd2;
            6'h25: aop = 3'd3;
            6'h2A: aop = 3'd4;
            default: fn_ok = 1'b0;
        endcase
        for (int i = 0; i <= wf; i++) begin
            o = st(1); o.mem_req = 1'b1; o.mem_read = 1'b1;
            if (i == wf) begin o.ir_write = 1'b1; o.pc_write = 1'b1; end
            push(i == wf, 1'($urandom_range(0, 1)), o);
        end
        exp_stall += wf;
        push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), st(2));
        case (op)
            6'h00: if (fn_ok) begin
                o = st(3); o.alu_op = aop;
                push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), o);
                o = st(8); o.reg_dst = 1'b1; o.reg_write = 1'b1; o.instr_done = 1'b1;
                push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), o);
            end else bad = 1'b1;
            6'h08: begin
                o = st(4); o.alu_src = 1'b1;
                push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), o);
                o = st(9); o.reg_write = 1'b1; o.instr_done = 1'b1;
                push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), o);
            end
            6'h23, 6'h2B: begin
                o = st(5); o.alu_src = 1'b1;
                push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), o);
                for (int i = 0; i <= wm; i++) begin
                    o = st(op == 6'h23 ? 6 : 7); o.mem_req = 1'b1; o.iord = 1'b1;
                    if (op == 6'h23) o.mem_read = 1'b1;
                    else begin
                        o.mem_write = 1'b1;
                        o.instr_done = (i == wm);
                    end
                    push(i == wm, 1'($urandom_range(0, 1)), o);
                end
                exp_stall += wm;
                if (op == 6'h23) begin
                    o = st(10); o.reg_write = 1'b1; o.mem_to_reg = 1'b1; o.instr_done = 1'b1;
                    push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), o);
                end
            end
            6'h04: begin
                o = st(11); o.alu_op = 3'd1; o.pc_src = 2'b01; o.pc_write = z; o.instr_done = 1'b1;
                push(1'($urandom_range(0, 1)), z, o);
            end
            6'h02: begin
                o = st(12); o.pc_write = 1'b1; o.pc_src = 2'b10; o.instr_done = 1'b1;
                push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), o);
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            o = st(13); o.illegal = 1'b1; o.instr_done = 1'b1;
            push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), o);
        end else begin
            exp_retired++;
        end
    endtask

    // Replays up to n queued cycles (n < 0: all). Entered and left at posedge+1.
    task automatic run_trace(input int n);
        cyc_t c;
        int k;
        k = (n < 0 || n > trace.size()) ? trace.size() : n;
        for (int i = 0; i < k; i++) begin
            c = trace.pop_front();
            opcode = c.op; funct = c.fn; mem_ready = c.rdy; zero = c.z;
            #1;
            total++;
            if (act !== c.exp)
                $display("FAIL cycle_%0d: outputs got %h expected %h (state got %0d expected %0d)",
                         cyc_no, act, c.exp, act.state, c.exp.state);
            else passed++;
            cyc_no++;
            @(posedge clk); #1;
        end
    endtask

    task automatic apply_reset();
        mem_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        total++;
        if (act !== '0) $display("FAIL reset_async: outputs got %h expected 0", act);
        else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        total++;
        if (act !== '0) $display("FAIL reset_idle: outputs got %h expected 0", act);
        else passed++;
        exp_retired = 0;
        exp_stall = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        total++;
        if (act !== '0) $display("FAIL reset_hold: outputs got %h expected 0", act);
        else passed++;
        apply_reset();
    endtask

    task automatic test_add();
        model_instr(6'h00, 6'h20, 1'b0, 0, 0);
        run_trace(-1);
    endtask

    task automatic test_lw_wait();
        model_instr(6'h23, 6'h11, 1'b0, 0, 2);
        run_trace(-1);
    endtask

    task automatic test_beq();
        model_instr(6'h04, 6'h00, 1'b1, 0, 0);
        model_instr(6'h04, 6'h00, 1'b0, 1, 0);
        run_trace(-1);
    endtask

    task automatic test_illegal();
        model_instr(6'h3F, 6'h20, 1'b0, 0, 0);
        model_instr(6'h00, 6'h01, 1'b0, 0, 0);
        run_trace(-1);
    endtask

    task automatic test_perf();
`ifdef MIPS_CTRL_PERF_EN
        apply_reset();
        model_instr(6'h00, 6'h20, 1'b0, 0, 0);
        model_instr(6'h23, 6'h00, 1'b0, 0, 2);
        model_instr(6'h3F, 6'h00, 1'b0, 0, 0);
        run_trace(-1);
        total++;
        if (retired_cnt !== 32'd2) $display("FAIL perf_retired: got %0d expected 2", retired_cnt);
        else passed++;
        total++;
        if (stall_cnt !== 32'd2) $display("FAIL perf_stall: got %0d expected 2", stall_cnt);
        else passed++;
`endif
    endtask

    task automatic test_reset_mid_write();
        outs_t o;
        model_instr(6'h2B, 6'h00, 1'b0, 0, 3);
        run_trace(5);
        trace.delete();
        mem_ready = 1'b0;
        #1;
        total++;
        if (state !== 4'd7 || mem_write !== 1'b1)
            $display("FAIL mid_write_entry: state got %0d mem_write %b expected 7 and 1", state, mem_write);
        else passed++;
        apply_reset();
        o = st(1); o.mem_req = 1'b1; o.mem_read = 1'b1;
        #1;
        total++;
        if (act !== o) $display("FAIL after_abort_fetch: outputs got %h expected %h", act, o);
        else passed++;
        exp_stall++;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [5:0] op, fn;
        for (int n = 0; n < 60; n++) begin
            fn = 6'($urandom);
            case ($urandom_range(0, 7))
                0: begin op = 6'h00; fn = legal_fns[$urandom_range(0, 4)]; end
                1: op = 6'h08;
                2: op = 6'h23;
                3: op = 6'h2B;
                4: op = 6'h04;
                5: op = 6'h02;
                6: do op = 6'($urandom); while (op inside {6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02});
                default: begin
                    op = 6'h00;
                    do fn = 6'($urandom); while (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A});
                end
            endcase
            model_instr(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
        end
        run_trace(-1);
`ifdef MIPS_CTRL_PERF_EN
        total++;
        if (retired_cnt !== 32'(exp_retired))
            $display("FAIL rand_retired: got %0d expected %0d", retired_cnt, exp_retired);
        else passed++;
        total++;
        if (stall_cnt !== 32'(exp_stall))
            $display("FAIL rand_stall: got %0d expected %0d", stall_cnt, exp_stall);
        else passed++;
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add();
        test_lw_wait();
        test_beq();
        test_illegal();
        test_perf();
        test_reset_mid_write();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multi-cycle control FSM for the MIPS datapath. Decodes opcode/funct latched in the instruction register and sequences fetch, decode, execute, memory and write-back. Drives every datapath select: `reg_dst` (write-register mux), `alu_src`, `mem_to_reg` and `pc_src`. Handshakes with a variable-latency memory through `mem_req`/`mem_ready`.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `opcode`  in  6  IR[31:26]
- `funct`  in  6  IR[5:0]
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory completes the current access this cycle
- `mem_req`  out  1  memory access request
- `mem_read`  out  1  read access
- `mem_write`  out  1  write access
- `iord`  out  1  0 = PC address, 1 = ALU-out address
- `ir_write`  out  1  load IR
- `reg_dst`  out  1  0 = rt, 1 = rd
- `reg_write`  out  1  register file write enable
- `mem_to_reg`  out  1  0 = ALU-out, 1 = MDR
- `alu_src`  out  1  0 = rt data, 1 = sign-extended immediate
- `alu_op`  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt
- `pc_write`  out  1  PC load
- `pc_src`  out  2  00 = PC+4, 01 = branch target, 10 = jump target
- `instr_done`  out  1  one-cycle pulse on the final cycle of each instruction
- `illegal`  out  1  one-cycle pulse on an unsupported opcode/funct
- `state`  out  4  current state, for debug

## Operation
- Moore FSM; outputs decode from current state only, except ready-qualified strobes.
- States:
  - IDLE=0: all outputs 0. Goes to FETCH unconditionally.
  - FETCH=1: `mem_req`=`mem_read`=1, `iord`=0. Holds while `mem_ready`=0. On `mem_ready`=1: `ir_write`=1, `pc_write`=1, `pc_src`=00; next state DECODE.
  - DECODE=2: branches on opcode:
    - 0x00 with legal funct → EXEC_R
    - 0x08 → EXEC_I
    - 0x23/0x2B → MEM_ADDR
    - 0x04 → BRANCH
    - 0x02 → JUMP
    - anything else → ILLEGAL
  - EXEC_R=3: `alu_src`=0; `alu_op` from funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt. Any other funct is routed to ILLEGAL from DECODE.
  - EXEC_I=4: `alu_src`=1, `alu_op`=add.
  - MEM_ADDR=5: `alu_src`=1, `alu_op`=add. Goes to MEM_RD for lw, MEM_WR for sw.
  - MEM_RD=6: `mem_req`=`mem_read`=1, `iord`=1. Waits for `mem_ready`, then WB_MEM.
  - MEM_WR=7: `mem_req`=`mem_write`=1, `iord`=1. On `mem_ready`: `instr_done`=1, then FETCH.
  - WB_R=8: `reg_dst`=1, `reg_write`=1, `mem_to_reg`=0.
  - WB_I=9: `reg_dst`=0, `reg_write`=1, `mem_to_reg`=0.
  - WB_MEM=10: `reg_dst`=0, `reg_write`=1, `mem_to_reg`=1.
  - BRANCH=11: `alu_op`=sub, `alu_src`=0, `pc_src`=01, `pc_write`=`zero`.
  - JUMP=12: `pc_write`=1, `pc_src`=10.
  - ILLEGAL=13: `illegal`=1, no writes.
- WB_*, BRANCH, JUMP and ILLEGAL assert `instr_done`=1 and return to FETCH.
- Unused state codes 14/15 go to IDLE with all outputs 0.
- `mem_ready` outside FETCH/MEM_RD/MEM_WR is ignored.

## Timing
- Reset: `state`=IDLE. Every output is 0 while `rst_n`=0 and in the first cycle after release.
- Reset asserted mid-instruction aborts it immediately. Any pending access is dropped and no write strobe appears.
- Cycles per instruction with zero-wait memory (`mem_ready` high in the first cycle): R/addi/sw=4, lw=5, beq=3, j=3. Each wait cycle adds one.
- `mem_req` holds steady, with address select stable, until `mem_ready` is sampled high.
- `instr_done` and `illegal` are single-cycle pulses; there is never back-to-back `instr_done`.

## Configuration
- `MIPS_CTRL_PERF_EN` defined: adds two outputs.
  - `retired_cnt` [31:0]: counts `instr_done` pulses that are not `illegal`.
  - `stall_cnt` [31:0]: counts cycles in FETCH/MEM_RD/MEM_WR with `mem_ready`=0.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

## Structure
- Package `mips_ctrl_pkg`: state encoding constants, opcode/funct constants, `alu_op` codes, `pc_src` codes.
- Sub-module `mips_alu_decode`: combinational funct → {`alu_op`, legal}; used by DECODE and EXEC_R.

## Test plan
- Reset then `add` (opcode 0, funct 0x20), `mem_ready` always 1 → states 1,2,3,8; in WB_R `reg_dst`=1, `reg_write`=1; `instr_done` 4 cycles after FETCH entry.
- `lw` (0x23) with `mem_ready` low for 2 cycles in MEM_RD → `mem_req`/`iord`=1 held for 3 cycles; WB_MEM has `mem_to_reg`=1, `reg_dst`=0; 7 cycles total.
- `beq` (0x04) with `zero`=1, then with `zero`=0 → `pc_write`=1 with `pc_src`=01 in BRANCH, then `pc_write`=0; both take 3 cycles.
- Opcode 0x3F, and opcode 0 with funct 0x01 → ILLEGAL, `illegal` pulse, no `reg_write`/`mem_write`, back to FETCH.
- Assert `rst_n`=0 during MEM_WR with `mem_ready`=0 → outputs 0 asynchronously; after release IDLE → FETCH, no `mem_write` seen.
- With `MIPS_CTRL_PERF_EN`: run add, lw (2 waits), illegal → `retired_cnt`=2, `stall_cnt`=2.
